mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multicycle main control unit for the MIPS core. A Moore state machine sequences fetch, decode, execute, memory and write-back. It drives the datapath enables, the multiplexer selects and the 3-bit ALUOp consumed by the ALU control decoder. It inserts parameterised memory wait cycles and halts the core on `break` or an unsupported opcode.

## Interface
- MEM_WAIT, 1: extra cycles memory needs after an address/command is presented before data is valid or a write completes (0..7).

- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low; all state and outputs forced to reset values while low.
- opcode  in  6  instruction bits [31:26] from the instruction register.
- break_in  in  1  break flag from the ALU control decoder (funct == 0x0d).
- zero  in  1  ALU zero flag.
- pc_en  out  1  PC load enable (combinational, see Operation).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mdr_write  out  1  memory data register load.
- reg_write  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = imm<<16.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  3  000 = add, 001 = subtract, 010 = decode funct.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- halted  out  1  core stopped.
- illegal  out  1  halted because of an unsupported opcode.
- state_dbg  out  5  current state encoding.

## Operation
- States and encodings:
  - RESET 0
  - FETCH 1
  - FETCH_WAIT 2
  - DECODE 3
  - MEM_ADDR 4
  - MEM_READ 5
  - MEM_READ_WAIT 6
  - LW_WB 7
  - MEM_WRITE 8
  - MEM_WRITE_WAIT 9
  - R_EXEC 10
  - R_WB 11
  - BRANCH 12
  - JUMP 13
  - ADDI_EXEC 14
  - ADDI_WB 15
  - LUI_WB 16
  - HALT 17
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2b, beq 0x04, bne 0x05, j 0x02, addi 0x08, lui 0x0f.
- All outputs except pc_en are a function of state only. Every signal not listed for a state is 0.
- RESET: go to FETCH.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00, pc_write.
  - Load wait counter with MEM_WAIT.
  - Go to FETCH_WAIT if MEM_WAIT>0, else DECODE with ir_write asserted in FETCH.
- FETCH_WAIT: decrement the counter. On the cycle the counter reaches 0, assert ir_write and go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state by opcode: lw/sw → MEM_ADDR; R-type → R_EXEC, or HALT if break_in=1; beq/bne → BRANCH; j → JUMP; addi → ADDI_EXEC; lui → LUI_WB.
  - Any other opcode → HALT with illegal set.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: iord=1. Load the counter. If MEM_WAIT=0, assert mdr_write and go to LW_WB; otherwise go to MEM_READ_WAIT.
- MEM_READ_WAIT: iord=1. Decrement the counter; at 0, assert mdr_write and go to LW_WB.
- LW_WB: reg_write, reg_dst=0, mem_to_reg=01. Then FETCH.
- MEM_WRITE: iord=1, mem_write. Load the counter. Go to MEM_WRITE_WAIT if MEM_WAIT>0, else FETCH.
- MEM_WRITE_WAIT: iord=1, mem_write held. Decrement the counter; at 0, go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Then R_WB.
- R_WB: reg_write, reg_dst=1, mem_to_reg=00. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_write_cond. Then FETCH.
- JUMP: pc_source=10, pc_write. Then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000. Then ADDI_WB.
- ADDI_WB: reg_write, reg_dst=0, mem_to_reg=00. Then FETCH.
- LUI_WB: reg_write, reg_dst=0, mem_to_reg=10. Then FETCH.
- HALT: halted=1. All enables and strobes stay 0. State is sticky until reset.
- pc_en = pc_write | (pc_write_cond & (zero ^ (opcode==0x05))). Opcode is stable from the IR in BRANCH.
- Wait counter is 3 bits. MEM_WAIT is clamped to 0..7 by construction.

## Timing
- Reset values: state=RESET, every output 0, illegal=0, wait counter 0.
- The first rising edge after reset deasserts moves RESET → FETCH. The first fetch completes DECODE at cycle 3+MEM_WAIT.
- With W = MEM_WAIT, cycles per instruction from FETCH entry to the next FETCH entry:
  - R-type, addi: 4+W
  - lui: 3+W
  - lw: 5+2W
  - sw: 4+2W
  - beq, bne, j: 3+W
- ir_write and mdr_write are single-cycle pulses.
- mem_write stays asserted for exactly W+1 cycles per store.
- Asserting reset in any state, including mid-wait or HALT, immediately forces RESET and zeroes all outputs. No memory write may be emitted after reset falls.
- break_in is sampled only in DECODE. Its value in other states is ignored.

## Test plan
- W=0, R-type add (opcode 0x00, break_in=0) → states 1,3,10,11,1. alu_op=010 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB. CPI 4.
- W=2, lw → FETCH_WAIT held 2 cycles. ir_write fires on the second wait cycle; mdr_write after 2 MEM_READ_WAIT cycles; LW_WB has mem_to_reg=01. CPI 9.
- W=1, beq with zero=1 → pc_en=1 in BRANCH. Same with zero=0 → pc_en=0. bne with zero=0 → pc_en=1. alu_op=001 in each case.
- W=0, sw → mem_write high exactly 1 cycle with iord=1, then FETCH. reg_write never asserted.
- Opcode 0x3f in DECODE → HALT, halted=1, illegal=1, held for 20 cycles. R-type with break_in=1 → HALT with illegal=0.
- reset pulled low during MEM_WRITE_WAIT (W=3) → mem_write drops in the same cycle, state_dbg=0. After release the core restarts at FETCH.

Source files
------------

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: Moore sequencer for fetch/decode/execute/mem/wb.
// Outputs are registered from the next state; only pc_en is combinational.
module mips_control_fsm #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       break_in,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       illegal,
  output logic [4:0] state_dbg
);

  localparam logic [2:0] W =
    (MEM_WAIT > 7) ? 3'd7 : 3'(MEM_WAIT);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  typedef enum logic [4:0] {
    S_RESET          = 5'd0,
    S_FETCH          = 5'd1,
    S_FETCH_WAIT     = 5'd2,
    S_DECODE         = 5'd3,
    S_MEM_ADDR       = 5'd4,
    S_MEM_READ       = 5'd5,
    S_MEM_READ_WAIT  = 5'd6,
    S_LW_WB          = 5'd7,
    S_MEM_WRITE      = 5'd8,
    S_MEM_WRITE_WAIT = 5'd9,
    S_R_EXEC         = 5'd10,
    S_R_WB           = 5'd11,
    S_BRANCH         = 5'd12,
    S_JUMP           = 5'd13,
    S_ADDI_EXEC      = 5'd14,
    S_ADDI_WB        = 5'd15,
    S_LUI_WB         = 5'd16,
    S_HALT           = 5'd17
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctl_t;

  state_t     state;
  state_t     ns;
  logic [2:0] cnt;
  logic [2:0] ncnt;
  logic       nillegal;
  ctl_t       ctl;

  // cnt is the value held while sitting in s; a wait state ends when it hits 1
  function automatic ctl_t ctl_of(input state_t s, input logic [2:0] c);
    ctl_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.alu_src_b = 2'b01;
        o.pc_write  = 1'b1;
        o.ir_write  = (W == 3'd0);
      end
      S_FETCH_WAIT: o.ir_write = (c == 3'd1);
      S_DECODE: o.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        o.iord      = 1'b1;
        o.mdr_write = (W == 3'd0);
      end
      S_MEM_READ_WAIT: begin
        o.iord      = 1'b1;
        o.mdr_write = (c == 3'd1);
      end
      S_LW_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 2'b01;
      end
      S_MEM_WRITE, S_MEM_WRITE_WAIT: begin
        o.iord      = 1'b1;
        o.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_op    = 3'b010;
      end
      S_R_WB: begin
        o.reg_write = 1'b1;
        o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o.alu_src_a     = 1'b1;
        o.alu_op        = 3'b001;
        o.pc_source     = 2'b01;
        o.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        o.pc_source = 2'b10;
        o.pc_write  = 1'b1;
      end
      S_ADDI_EXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
      end
      S_ADDI_WB: o.reg_write = 1'b1;
      S_LUI_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 2'b10;
      end
      S_HALT: o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    ns       = state;
    ncnt     = cnt;
    nillegal = illegal;
    case (state)
      S_RESET: begin
        ns   = S_FETCH;
        ncnt = 3'd0;
      end
      S_FETCH: begin
        ncnt = W;
        ns   = (W != 3'd0) ? S_FETCH_WAIT : S_DECODE;
      end
      S_FETCH_WAIT: begin
        ncnt = cnt - 3'd1;
        if (cnt <= 3'd1) ns = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          opcode == OP_LW,
          opcode == OP_SW:   ns = S_MEM_ADDR;
          opcode == OP_R:    ns = break_in ? S_HALT : S_R_EXEC;
          opcode == OP_BEQ,
          opcode == OP_BNE:  ns = S_BRANCH;
          opcode == OP_J:    ns = S_JUMP;
          opcode == OP_ADDI: ns = S_ADDI_EXEC;
          opcode == OP_LUI:  ns = S_LUI_WB;
          default: begin
            ns       = S_HALT;
            nillegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:
        ns = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        ncnt = W;
        ns   = (W != 3'd0) ? S_MEM_READ_WAIT : S_LW_WB;
      end
      S_MEM_READ_WAIT: begin
        ncnt = cnt - 3'd1;
        if (cnt <= 3'd1) ns = S_LW_WB;
      end
      S_MEM_WRITE: begin
        ncnt = W;
        ns   = (W != 3'd0) ? S_MEM_WRITE_WAIT : S_FETCH;
      end
      S_MEM_WRITE_WAIT: begin
        ncnt = cnt - 3'd1;
        if (cnt <= 3'd1) ns = S_FETCH;
      end
      S_R_EXEC:    ns = S_R_WB;
      S_ADDI_EXEC: ns = S_ADDI_WB;
      S_R_WB,
      S_LW_WB,
      S_BRANCH,
      S_JUMP,
      S_ADDI_WB,
      S_LUI_WB:    ns = S_FETCH;
      S_HALT:      ns = S_HALT;
      default:     ns = S_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_RESET;
      cnt     <= 3'd0;
      illegal <= 1'b0;
      ctl     <= '0;
    end else begin
      state   <= ns;
      cnt     <= ncnt;
      illegal <= nillegal;
      ctl     <= ctl_of(ns, ncnt);
    end
  end

  // bne inverts the sense of the zero flag
  assign pc_en = ctl.pc_write |
    (ctl.pc_write_cond & (zero ^ (opcode == OP_BNE)));

  assign iord       = ctl.iord;
  assign mem_write  = ctl.mem_write;
  assign ir_write   = ctl.ir_write;
  assign mdr_write  = ctl.mdr_write;
  assign reg_write  = ctl.reg_write;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign pc_source  = ctl.pc_source;
  assign halted     = ctl.halted;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: four instances, MEM_WAIT = 0..3.
// Per-cycle expected output vectors are queued by the driver, checked at negedge.
module tb_mips_control_fsm;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal;
    logic [4:0] st;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       break_in = 1'b0;
  logic       zero = 1'b0;

  logic [3:0] pc_en_w, iord_w, mem_write_w, ir_write_w;
  logic [3:0] mdr_write_w, reg_write_w, reg_dst_w, alu_src_a_w;
  logic [3:0] halted_w, illegal_w;
  logic [1:0] mem_to_reg_w [4];
  logic [1:0] alu_src_b_w  [4];
  logic [2:0] alu_op_w     [4];
  logic [1:0] pc_source_w  [4];
  logic [4:0] state_w      [4];
  vec_t       obs [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mips_control_fsm #(.MEM_WAIT(g)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .opcode     (opcode),
      .break_in   (break_in),
      .zero       (zero),
      .pc_en      (pc_en_w[g]),
      .iord       (iord_w[g]),
      .mem_write  (mem_write_w[g]),
      .ir_write   (ir_write_w[g]),
      .mdr_write  (mdr_write_w[g]),
      .reg_write  (reg_write_w[g]),
      .reg_dst    (reg_dst_w[g]),
      .mem_to_reg (mem_to_reg_w[g]),
      .alu_src_a  (alu_src_a_w[g]),
      .alu_src_b  (alu_src_b_w[g]),
      .alu_op     (alu_op_w[g]),
      .pc_source  (pc_source_w[g]),
      .halted     (halted_w[g]),
      .illegal    (illegal_w[g]),
      .state_dbg  (state_w[g])
    );
    assign obs[g] = {pc_en_w[g], iord_w[g], mem_write_w[g],
                     ir_write_w[g], mdr_write_w[g], reg_write_w[g],
                     reg_dst_w[g], mem_to_reg_w[g], alu_src_a_w[g],
                     alu_src_b_w[g], alu_op_w[g], pc_source_w[g],
                     halted_w[g], illegal_w[g], state_w[g]};
  end

  always #5 clock = ~clock;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    sel     = 0;
  string scen    = "init";
  vec_t  q[$];
  vec_t  mexp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      mexp = q.pop_front();
      chk($sformatf("%s st%0d", scen, mexp.st),
          32'(obs[sel]), 32'(mexp));
    end
  end

  // Expected outputs for each state, straight from the control table
  function automatic vec_t ex(input int s, input bit irw, input bit mdrw,
                              input bit br, input bit ill);
    vec_t v;
    v = '0;
    v.st = 5'(s);
    case (s)
      1: begin v.alu_src_b = 2'b01; v.pc_en = 1; v.ir_write = irw; end
      2: v.ir_write = irw;
      3: v.alu_src_b = 2'b11;
      4: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      5, 6: begin v.iord = 1; v.mdr_write = mdrw; end
      7: begin v.reg_write = 1; v.mem_to_reg = 2'b01; end
      8, 9: begin v.iord = 1; v.mem_write = 1; end
      10: begin v.alu_src_a = 1; v.alu_op = 3'b010; end
      11: begin v.reg_write = 1; v.reg_dst = 1; end
      12: begin
        v.alu_src_a = 1; v.alu_op = 3'b001;
        v.pc_source = 2'b01; v.pc_en = br;
      end
      13: begin v.pc_source = 2'b10; v.pc_en = 1; end
      14: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      15: v.reg_write = 1;
      16: begin v.reg_write = 1; v.mem_to_reg = 2'b10; end
      17: begin v.halted = 1; v.illegal = ill; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic st(input int s, input bit irw = 0, input bit mdrw = 0,
                    input bit br = 0, input bit ill = 0);
    q.push_back(ex(s, irw, mdrw, br, ill));
    @(posedge clock);
    #1;
  endtask

  task automatic start(input string name, input int inst,
                       input logic [5:0] op, input logic brk,
                       input logic z);
    scen     = name;
    sel      = inst;
    opcode   = op;
    break_in = brk;
    zero     = z;
    reset    = 1'b0;
    st(0);
    st(0);
    reset    = 1'b1;
    st(0);
  endtask

  // One branch instruction at W=1 starting from reset
  task automatic br_case(input string name, input logic [5:0] op,
                         input logic z, input bit taken);
    start(name, 1, op, 1'b0, z);
    st(1); st(2, 1); st(3); st(12, 0, 0, taken); st(1); st(2, 1);
  endtask

  initial begin
    @(posedge clock);
    #1;

    start("radd_w0", 0, 6'h00, 1'b0, 1'b0);
    st(1, 1); st(3); st(10); st(11); st(1, 1); st(3); st(10);

    start("lw_w2", 2, 6'h23, 1'b0, 1'b0);
    st(1); st(2); st(2, 1); st(3); st(4);
    st(5); st(6); st(6, 0, 1); st(7); st(1); st(2);

    br_case("beq_z1", 6'h04, 1'b1, 1'b1);
    br_case("beq_z0", 6'h04, 1'b0, 1'b0);
    br_case("bne_z0", 6'h05, 1'b0, 1'b1);
    br_case("bne_z1", 6'h05, 1'b1, 1'b0);

    start("sw_w0", 0, 6'h2b, 1'b0, 1'b0);
    st(1, 1); st(3); st(4); st(8); st(1, 1); st(3); st(4); st(8); st(1, 1);

    start("addi_w1_brk", 1, 6'h08, 1'b1, 1'b0);
    st(1); st(2, 1); st(3); st(14); st(15); st(1); st(2, 1);

    start("lui_w3", 3, 6'h0f, 1'b0, 1'b0);
    st(1); st(2); st(2); st(2, 1); st(3); st(16); st(1);

    start("j_w2", 2, 6'h02, 1'b0, 1'b0);
    st(1); st(2); st(2, 1); st(3); st(13); st(1);

    start("illegal_w0", 0, 6'h3f, 1'b0, 1'b0);
    st(1, 1); st(3);
    for (int i = 0; i < 20; i++) st(17, 0, 0, 0, 1);

    start("break_w0", 0, 6'h00, 1'b1, 1'b0);
    st(1, 1); st(3);
    for (int i = 0; i < 5; i++) st(17);

    start("sw_w3_rst", 3, 6'h2b, 1'b0, 1'b0);
    st(1); st(2); st(2); st(2, 1); st(3); st(4);
    st(8); st(9); st(9);
    reset = 1'b0;
    st(0); st(0);
    reset = 1'b1;
    st(0); st(1); st(2); st(2); st(2, 1); st(3);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
